// File: rtl/w450_mem.sv
// Dual-read, single-write memory with a power-up clear sweep and a byte-stream
// program loader that keeps the processor in reset until the load completes.
module w450_mem #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] mem_rd_addr1,
    output logic [n-1:0] mem_rd_data1,
    input  logic [n-1:0] mem_rd_addr2,
    output logic [n-1:0] mem_rd_data2,
    input  logic [n-1:0] mem_wr_addr,
    input  logic [n-1:0] mem_wr_data,
    input  logic         mem_wr_en,
    input  logic         ld_start,
    input  logic         ld_valid,
    input  logic [n-1:0] ld_data,
    input  logic         ld_last,
    output logic         ld_ready,
    output logic         cpu_hold
);

    localparam int DEPTH = 2 ** n;
    localparam logic [n-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        RUN
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [n-1:0] ptr;
    logic [n-1:0] next_ptr;
    logic         wr_en;
    logic [n-1:0] wr_addr;
    logic [n-1:0] wr_data;

    logic [n-1:0] mem [DEPTH];

    assign mem_rd_data1 = mem[mem_rd_addr1];
    assign mem_rd_data2 = mem[mem_rd_addr2];

    // Outputs are registered from next_state so they track the state register exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= CLEAR;
            ptr      <= '0;
            ld_ready <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            state    <= next_state;
            ptr      <= next_ptr;
            ld_ready <= (next_state == LOAD);
            cpu_hold <= (next_state != RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        next_state = state;
        next_ptr   = ptr;
        wr_en      = 1'b0;
        wr_addr    = ptr;
        wr_data    = '0;
        unique case (state)
            CLEAR: begin
                wr_en    = 1'b1;
                next_ptr = ptr + n'(1);
                if (ptr == LAST_ADDR) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (ld_valid) begin
                    wr_en    = 1'b1;
                    wr_data  = ld_data;
                    next_ptr = ptr + n'(1);
                    if (ld_last || ptr == LAST_ADDR) begin
                        next_state = RUN;
                        next_ptr   = '0;
                    end
                end
            end
            RUN: begin
                if (mem_wr_en) begin
                    wr_en   = 1'b1;
                    wr_addr = mem_wr_addr;
                    wr_data = mem_wr_data;
                end
                if (ld_start) begin
                    next_state = LOAD;
                    next_ptr   = '0;
                end
            end
            default: begin
                next_state = CLEAR;
                next_ptr   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_w450_mem.sv
// Self-checking bench for w450_mem: directed sequences, a vector table for
// RUN-mode read/write, and randomized traffic against a behavioural model.
module tb_w450_mem;

    logic       clk;
    logic       reset;
    logic [7:0] mem_rd_addr1;
    logic [7:0] mem_rd_data1;
    logic [7:0] mem_rd_addr2;
    logic [7:0] mem_rd_data2;
    logic [7:0] mem_wr_addr;
    logic [7:0] mem_wr_data;
    logic       mem_wr_en;
    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_last;
    logic       ld_ready;
    logic       cpu_hold;

    int n_checks;
    int n_fail;

    // Reference model: memory image plus sweep/load progress counters.
    logic [7:0] model_mem [256];
    int         clear_left;
    bit         loading;
    int         load_pos;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_addr;
        logic [7:0] wr_data;
        logic [7:0] rd1;
        logic [7:0] rd2;
        logic [7:0] pre1;
        logic [7:0] pre2;
        logic [7:0] post1;
        logic [7:0] post2;
    } vec_t;

    vec_t vecs [5];

    w450_mem #(.n(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_rd_addr1 (mem_rd_addr1),
        .mem_rd_data1 (mem_rd_data1),
        .mem_rd_addr2 (mem_rd_addr2),
        .mem_rd_data2 (mem_rd_data2),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .ld_start     (ld_start),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .cpu_hold     (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        clear_left = 256;
        loading    = 1'b0;
        load_pos   = 0;
    endtask

    task automatic model_edge();
        if (clear_left > 0) begin
            model_mem[256 - clear_left] = 8'h00;
            clear_left--;
            if (clear_left == 0) begin
                loading  = 1'b1;
                load_pos = 0;
            end
        end else if (loading) begin
            if (ld_valid) begin
                model_mem[load_pos] = ld_data;
                load_pos++;
                if (ld_last || load_pos == 256) loading = 1'b0;
            end
        end else begin
            if (mem_wr_en) model_mem[mem_wr_addr] = mem_wr_data;
            if (ld_start) begin
                loading  = 1'b1;
                load_pos = 0;
            end
        end
    endtask

    // One clock: update the model with the inputs present, then compare flags.
    task automatic applyStimulus();
        model_edge();
        @(posedge clk);
        #1;
        checkFlag("ld_ready", ld_ready, (clear_left == 0) && loading);
        checkFlag("cpu_hold", cpu_hold, !((clear_left == 0) && !loading));
    endtask

    task automatic idle_inputs();
        mem_wr_en   = 1'b0;
        mem_wr_addr = 8'h00;
        mem_wr_data = 8'h00;
        ld_start    = 1'b0;
        ld_valid    = 1'b0;
        ld_data     = 8'h00;
        ld_last     = 1'b0;
    endtask

    task automatic run_clear(input int limit, output int cycles);
        cycles = 0;
        while (!ld_ready && cycles < limit) begin
            mem_wr_en   = 1'($urandom_range(0, 1));
            mem_wr_addr = 8'($urandom);
            mem_wr_data = 8'($urandom);
            ld_start    = 1'($urandom_range(0, 1));
            ld_valid    = 1'($urandom_range(0, 1));
            ld_data     = 8'($urandom);
            ld_last     = 1'($urandom_range(0, 1));
            applyStimulus();
            cycles++;
        end
        idle_inputs();
    endtask

    task automatic load_byte(input logic [7:0] data, input logic last);
        int gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) begin
            ld_valid  = 1'b0;
            ld_last   = 1'($urandom_range(0, 1));
            ld_data   = 8'($urandom);
            mem_wr_en = 1'b1;
            applyStimulus();
        end
        ld_valid    = 1'b1;
        ld_data     = data;
        ld_last     = last;
        mem_wr_en   = 1'b1;
        mem_wr_addr = 8'($urandom);
        mem_wr_data = 8'($urandom);
        ld_start    = 1'($urandom_range(0, 1));
        applyStimulus();
        idle_inputs();
    endtask

    task automatic read_mem(input string name, input logic [7:0] addr, input logic [7:0] expected);
        mem_rd_addr1 = addr;
        mem_rd_addr2 = addr;
        #1;
        checkOutput({name, "_p1"}, mem_rd_data1, expected);
        checkOutput({name, "_p2"}, mem_rd_data2, expected);
        applyStimulus();
    endtask

    task automatic check_all_zero();
        for (int i = 0; i < 256; i++) begin
            mem_rd_addr1 = 8'(i);
            mem_rd_addr2 = 8'(255 - i);
            #1;
            checkOutput("zero_p1", mem_rd_data1, 8'h00);
            checkOutput("zero_p2", mem_rd_data2, 8'h00);
            applyStimulus();
        end
    endtask

    task automatic pulse_ld_start();
        ld_start = 1'b1;
        applyStimulus();
        ld_start = 1'b0;
        checkFlag("reload_ready", ld_ready, 1'b1);
    endtask

    task automatic async_reset_now(input string name);
        #3;
        reset = 1'b0;
        #1;
        checkFlag({name, "_hold"}, cpu_hold, 1'b1);
        checkFlag({name, "_ready"}, ld_ready, 1'b0);
        model_reset();
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int cycles;
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{1'b1, 8'h10, 8'h33, 8'h10, 8'h00, 8'h00, 8'hA1, 8'h33, 8'hA1};
        vecs[1] = '{1'b0, 8'h10, 8'h99, 8'h10, 8'h40, 8'h33, 8'h7E, 8'h33, 8'h7E};
        vecs[2] = '{1'b1, 8'hFF, 8'hC4, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hC4, 8'hC4};
        vecs[3] = '{1'b1, 8'h01, 8'h5A, 8'h02, 8'h01, 8'h22, 8'h05, 8'h22, 8'h5A};
        vecs[4] = '{1'b1, 8'h10, 8'h44, 8'h10, 8'h01, 8'h33, 8'h5A, 8'h44, 8'h5A};

        reset        = 1'b0;
        mem_rd_addr1 = 8'h00;
        mem_rd_addr2 = 8'h00;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checkFlag("reset_hold", cpu_hold, 1'b1);
        checkFlag("reset_ready", ld_ready, 1'b0);
        reset = 1'b1;

        $display("[TB] power-up clear sweep");
        run_clear(300, cycles);
        checkOutput("clear_cycles", 8'(cycles), 8'(256));
        check_all_zero();

        $display("[TB] three-byte load");
        load_byte(8'hA1, 1'b0);
        load_byte(8'h05, 1'b0);
        load_byte(8'h22, 1'b1);
        checkFlag("load3_ready", ld_ready, 1'b0);
        checkFlag("load3_hold", cpu_hold, 1'b0);
        read_mem("load3_m0", 8'h00, 8'hA1);
        read_mem("load3_m1", 8'h01, 8'h05);
        read_mem("load3_m2", 8'h02, 8'h22);
        read_mem("load3_m3", 8'h03, 8'h00);

        $display("[TB] read during write");
        mem_rd_addr1 = 8'h40;
        mem_rd_addr2 = 8'h40;
        mem_wr_en    = 1'b1;
        mem_wr_addr  = 8'h40;
        mem_wr_data  = 8'h7E;
        #1;
        checkOutput("rdw_pre1", mem_rd_data1, 8'h00);
        checkOutput("rdw_pre2", mem_rd_data2, 8'h00);
        applyStimulus();
        idle_inputs();
        checkOutput("rdw_post1", mem_rd_data1, 8'h7E);
        checkOutput("rdw_post2", mem_rd_data2, 8'h7E);

        $display("[TB] run-mode vector table");
        for (int v = 0; v < 5; v++) begin
            mem_wr_en    = vecs[v].wr_en;
            mem_wr_addr  = vecs[v].wr_addr;
            mem_wr_data  = vecs[v].wr_data;
            mem_rd_addr1 = vecs[v].rd1;
            mem_rd_addr2 = vecs[v].rd2;
            #1;
            checkOutput("vec_pre1", mem_rd_data1, vecs[v].pre1);
            checkOutput("vec_pre2", mem_rd_data2, vecs[v].pre2);
            applyStimulus();
            checkOutput("vec_post1", mem_rd_data1, vecs[v].post1);
            checkOutput("vec_post2", mem_rd_data2, vecs[v].post2);
            idle_inputs();
        end

        $display("[TB] partial reload");
        pulse_ld_start();
        load_byte(8'h11, 1'b1);
        checkFlag("reload_hold", cpu_hold, 1'b0);
        read_mem("reload_m0", 8'h00, 8'h11);
        read_mem("reload_m1", 8'h01, 8'h5A);
        read_mem("reload_m40", 8'h40, 8'h7E);
        read_mem("reload_m10", 8'h10, 8'h44);
        read_mem("reload_mff", 8'hFF, 8'hC4);

        $display("[TB] randomized run traffic");
        for (int c = 0; c < 400; c++) begin
            mem_wr_en    = 1'($urandom_range(0, 1));
            mem_wr_addr  = 8'($urandom_range(0, 31));
            mem_wr_data  = 8'($urandom);
            mem_rd_addr1 = ($urandom_range(0, 1) == 1) ? mem_wr_addr : 8'($urandom_range(0, 31));
            mem_rd_addr2 = 8'($urandom_range(0, 31));
            #1;
            checkOutput("rand_p1", mem_rd_data1, model_mem[mem_rd_addr1]);
            checkOutput("rand_p2", mem_rd_data2, model_mem[mem_rd_addr2]);
            applyStimulus();
        end
        idle_inputs();

        $display("[TB] full 256-byte load without last");
        pulse_ld_start();
        for (int i = 0; i < 256; i++) begin
            load_byte(8'(i), 1'b0);
        end
        checkFlag("full_ready", ld_ready, 1'b0);
        checkFlag("full_hold", cpu_hold, 1'b0);
        read_mem("full_mff", 8'hFF, 8'hFF);
        read_mem("full_m00", 8'h00, 8'h00);
        read_mem("full_m80", 8'h80, 8'h80);

        $display("[TB] reset during load and during clear");
        pulse_ld_start();
        load_byte(8'hDE, 1'b0);
        load_byte(8'hAD, 1'b0);
        async_reset_now("rst_load");
        run_clear(100, cycles);
        async_reset_now("rst_clear");
        run_clear(300, cycles);
        checkOutput("reclear_cycles", 8'(cycles), 8'(256));
        check_all_zero();
        load_byte(8'h3C, 1'b1);
        checkFlag("final_hold", cpu_hold, 1'b0);
        read_mem("final_m0", 8'h00, 8'h3C);
        read_mem("final_m1", 8'h01, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
